// File: rtl/tetris_field_store_pkg.sv
// Shared playfield definitions: grid defaults, write op codes, line-clear states.
package tetris_field_store_pkg;
    localparam int COLS_D = 10;
    localparam int ROWS_D = 20;
    localparam int XW_D   = 8;
    localparam int YW_D   = 8;
    localparam int CW_D   = 5;

    typedef enum logic [1:0] {
        OP_SET  = 2'b00,
        OP_CLR  = 2'b01,
        OP_WIPE = 2'b10,
        OP_TGL  = 2'b11
    } wr_op_t;

    typedef enum logic [1:0] {
        LC_IDLE  = 2'b00,
        LC_SCAN  = 2'b01,
        LC_SHIFT = 2'b10,
        LC_DONE  = 2'b11
    } lc_state_t;
endpackage

// File: rtl/tetris_field_store_if.sv
// Game-side write channel into the back field (valid/ready handshake).
interface tetris_field_store_if #(
    parameter int XW = 8,
    parameter int YW = 8
);
    import tetris_field_store_pkg::*;

    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    wr_op_t        wr_op;

    modport master (output wr_valid, wr_x, wr_y, wr_op, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_op, output wr_ready);
endinterface

// File: rtl/tetris_line_clear.sv
// Line-clear sequencer: scans the back field bottom-up, one row per cycle,
// and requests a one-cycle shift whenever the row under the pointer is full.
module tetris_line_clear
    import tetris_field_store_pkg::*;
#(
    parameter int COLS = COLS_D,
    parameter int ROWS = ROWS_D,
    parameter int CW   = CW_D,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic                       vga_clk,
    input  logic                       rst,
    input  logic                       lc_start,
    input  logic [ROWS-1:0][COLS-1:0]  field,
    output lc_state_t                  state,
    output logic [RW-1:0]              row,
    output logic                       shift_en,
    output logic                       lc_busy,
    output logic                       lc_done,
    output logic [CW-1:0]              lc_count
);
    lc_state_t     state_n;
    logic [RW-1:0] row_n;
    logic [CW-1:0] cnt_n;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state    <= LC_IDLE;
            row      <= '0;
            lc_count <= '0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            lc_count <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = lc_count;
        case (state)
            LC_IDLE: if (lc_start) begin
                row_n   = RW'(ROWS - 1);
                cnt_n   = '0;
                state_n = LC_SCAN;
            end
            LC_SCAN: begin
                if (&field[row])    state_n = LC_SHIFT;
                else if (row == '0) state_n = LC_DONE;
                else                row_n   = row - 1'b1;
            end
            // The pointer stays put so the row that drops in gets re-checked.
            LC_SHIFT: begin
                state_n = LC_SCAN;
                if (lc_count != CW'(ROWS)) cnt_n = lc_count + 1'b1;
            end
            LC_DONE: state_n = LC_IDLE;
            default: state_n = LC_IDLE;
        endcase
    end

    assign shift_en = (state == LC_SHIFT);
    assign lc_busy  = (state != LC_IDLE);
    assign lc_done  = (state == LC_DONE);
endmodule

// File: rtl/tetris_field_store.sv
// Double-buffered playfield: game edits/line-clears the back field, the raster
// reads the front field, which is refreshed from back only at end of frame.
module tetris_field_store
    import tetris_field_store_pkg::*;
#(
    parameter int COLS = COLS_D,
    parameter int ROWS = ROWS_D,
    parameter int XW   = XW_D,
    parameter int YW   = YW_D,
    parameter int CW   = CW_D
) (
    input  logic                  vga_clk,
    input  logic                  rst,
    tetris_field_store_if.slave   wr,
    input  logic [XW-1:0]         x_coord,
    input  logic [YW-1:0]         y_coord,
    output logic                  coord_value,
    input  logic                  draw_finish,
    input  logic                  lc_start,
    output logic                  lc_busy,
    output logic                  lc_done,
    output logic [CW-1:0]         lc_count,
    input  logic                  commit_req,
    output logic                  commit_pending,
    output logic                  commit_ack
);
    localparam int XI = $clog2(COLS);
    localparam int YI = $clog2(ROWS);

    logic [ROWS-1:0][COLS-1:0] back, back_n, front;
    lc_state_t                 lc_state;
    logic [YI-1:0]             lc_row;
    logic                      shift_en, idle, wr_fire, wr_in, rd_in, copy;
    logic [XI-1:0]             wx, rx;
    logic [YI-1:0]             wy, ry;

    tetris_line_clear #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(YI)) u_lc (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .lc_start (lc_start),
        .field    (back),
        .state    (lc_state),
        .row      (lc_row),
        .shift_en (shift_en),
        .lc_busy  (lc_busy),
        .lc_done  (lc_done),
        .lc_count (lc_count)
    );

    assign idle        = (lc_state == LC_IDLE);
    assign wr.wr_ready = idle;
    assign wr_fire     = wr.wr_valid & idle;
    assign wr_in       = (wr.wr_x < XW'(COLS)) && (wr.wr_y < YW'(ROWS));
    assign wx          = wr.wr_x[XI-1:0];
    assign wy          = wr.wr_y[YI-1:0];

    // Writes only happen in IDLE and shifts only in SHIFT, so they never collide.
    always_comb begin
        back_n = back;
        if (shift_en) begin
            for (int i = ROWS - 1; i > 0; i--)
                if (i <= int'(lc_row)) back_n[i] = back[i-1];
            back_n[0] = '0;
        end else if (wr_fire) begin
            case (wr.wr_op)
                OP_WIPE: back_n = '0;
                OP_SET:  if (wr_in) back_n[wy][wx] = 1'b1;
                OP_CLR:  if (wr_in) back_n[wy][wx] = 1'b0;
                OP_TGL:  if (wr_in) back_n[wy][wx] = ~back[wy][wx];
                default: back_n = back;
            endcase
        end
    end

    assign copy = draw_finish & (commit_pending | commit_req) & idle;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            back           <= '0;
            front          <= '0;
            commit_pending <= 1'b0;
            commit_ack     <= 1'b0;
        end else begin
            back           <= back_n;
            if (copy) front <= back;
            commit_pending <= copy ? 1'b0 : (commit_pending | commit_req);
            commit_ack     <= copy;
        end
    end

    assign rd_in       = (x_coord < XW'(COLS)) && (y_coord < YW'(ROWS));
    assign rx          = x_coord[XI-1:0];
    assign ry          = y_coord[YI-1:0];
    assign coord_value = rd_in & front[ry][rx];
endmodule
